frame_commit_scheduler: RTL

- Sits between the host command source and the configuration controller's command_interface writer port.
- Buffers host register writes (bilinear matrices, ROI corners, DfDD constants, confidence minimum) into a batch. A batch is released only after the host commits it.
- The released batch is replayed one write per cycle during vertical blanking, so no datapath frame ever sees a half-updated matrix or ROI.

---
 rtl/frame_commit_pkg.sv | 21 ++
 rtl/cmd_fifo.sv | 71 +++++++
 rtl/frame_commit_scheduler.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/frame_commit_pkg.sv
// Shared types for the frame commit scheduler.
// Holds the scheduler state encoding, default bus widths and the default
// packed command word (address + data) stored in the batch FIFO.
package frame_commit_pkg;

  localparam int FCS_ADDR_WIDTH = 16;
  localparam int FCS_DATA_WIDTH = 32;
  localparam int FCS_DEPTH      = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DRAIN = 2'd2
  } fcs_state_e;

  typedef struct packed {
    logic [FCS_ADDR_WIDTH-1:0] addr;
    logic [FCS_DATA_WIDTH-1:0] data;
  } fcs_cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO holding one batch of host register writes.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (empties the FIFO)
//   push      : write wr_entry (ignored when full)
//   pop       : advance read pointer (ignored when empty)
//   wr_entry  : entry to store
//   rd_entry  : entry at the head of the FIFO (combinational)
//   full      : level == DEPTH
//   empty     : level == 0
//   level     : current occupancy, 0..DEPTH
module cmd_fifo
  import frame_commit_pkg::*;
#(
  parameter int  DEPTH   = FCS_DEPTH,
  parameter type entry_t = fcs_cmd_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  entry_t                   wr_entry,
  output entry_t                   rd_entry,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_LEVEL = DEPTH[PTR_W:0];

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == FULL_LEVEL);
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign rd_entry = mem[rd_ptr];

  // Storage has no reset; only the pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Pointers wrap naturally modulo DEPTH since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/frame_commit_scheduler.sv
// Frame commit scheduler: collects host register writes into a batch, holds
// the batch until the host commits it, then replays it one write per cycle
// during the next vertical blanking so no frame sees a half-updated config.
// Ports:
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   cmd_valid_i/addr/data : host write request; accepted when cmd_ready_o
//   cmd_ready_o           : high in IDLE while the FIFO is not full
//   commit_i              : closes the current batch (ignored if empty)
//   frame_end_i           : start of blanking; releases an armed batch
//   frame_start_i         : first active line (late detection only)
//   out_valid_o/addr/data : registered write strobe to the controller
//   busy_o                : high while a batch is armed or draining
//   level_o               : FIFO occupancy
// Optional feature, macro FRAME_COMMIT_LATE_FLAG_EN:
//   late_o     : sticky flag, drain overlapped the next active frame
//   late_clr_i : clears late_o (a simultaneous set wins)
module frame_commit_scheduler
  import frame_commit_pkg::*;
#(
  parameter int ADDR_WIDTH = FCS_ADDR_WIDTH,
  parameter int DATA_WIDTH = FCS_DATA_WIDTH,
  parameter int DEPTH      = FCS_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cmd_valid_i,
  input  logic [ADDR_WIDTH-1:0]    cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]    cmd_data_i,
  output logic                     cmd_ready_o,
  input  logic                     commit_i,
  input  logic                     frame_end_i,
  input  logic                     frame_start_i,
  output logic                     out_valid_o,
  output logic [ADDR_WIDTH-1:0]    out_addr_o,
  output logic [DATA_WIDTH-1:0]    out_data_o,
  output logic                     busy_o,
  output logic [$clog2(DEPTH):0]   level_o
`ifdef FRAME_COMMIT_LATE_FLAG_EN
  ,
  input  logic                     late_clr_i,
  output logic                     late_o
`endif
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam logic [LVL_W-1:0] LEVEL_ONE = LVL_W'(1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } cmd_t;

  fcs_state_e state;
  fcs_state_e next_state;
  cmd_t       wr_entry;
  cmd_t       head;
  logic       full;
  logic       empty;
  logic       push;
  logic       pop;

  assign wr_entry    = '{addr: cmd_addr_i, data: cmd_data_i};
  assign cmd_ready_o = (state == IDLE) && !full;
  assign push        = cmd_valid_i && cmd_ready_o;
  assign busy_o      = (state != IDLE);

  cmd_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (cmd_t)
  ) u_fifo (
    .clk      (clk_i),
    .rst      (rst_i),
    .push     (push),
    .pop      (pop),
    .wr_entry (wr_entry),
    .rd_entry (head),
    .full     (full),
    .empty    (empty),
    .level    (level_o)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A write accepted in the commit cycle counts toward a non-empty batch.
  // frame_end_i is only looked at once ARMED, so a frame_end in the commit
  // cycle leaves the batch waiting for the following blanking interval.
  // DRAIN leaves on the edge that pops the final entry.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        if (commit_i && (!empty || push)) begin
          next_state = ARMED;
        end
      end
      ARMED: begin
        if (frame_end_i) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        pop = !empty;
        if (empty || (level_o == LEVEL_ONE)) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Output stage registers the popped head; address/data hold between strobes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      out_addr_o  <= '0;
      out_data_o  <= '0;
    end else begin
      out_valid_o <= pop;
      if (pop) begin
        out_addr_o <= head.addr;
        out_data_o <= head.data;
      end
    end
  end

`ifdef FRAME_COMMIT_LATE_FLAG_EN
  logic late_set;

  assign late_set = frame_start_i &&
                    ((state == DRAIN) || ((state == ARMED) && frame_end_i));

  // Sticky late flag; a new late event takes priority over a clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      late_o <= 1'b0;
    end else if (late_set) begin
      late_o <= 1'b1;
    end else if (late_clr_i) begin
      late_o <= 1'b0;
    end
  end
`else
  logic unused_frame_start;
  assign unused_frame_start = frame_start_i;
`endif

endmodule
